// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_ctrl_n calculator controller.
// The top module's chain mode is built in only when CALC_CHAIN_EN is defined.
package calc_pkg;

    typedef enum logic [2:0] {
        OP1_ENTRY,
        OP2_ENTRY,
        EXEC,
        MUL_RUN,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Only the three legal one-hot codes count as operator presses.
    function automatic logic is_one_hot_op(input logic [2:0] code);
        return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier: one multiplier bit per clock, WIDTH steps,
// done pulses for one cycle once product holds the full 2*WIDTH result.
module seq_mult
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;

    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc <= '0;
                r_a   <= PW'(a_mag);
                r_b   <= b_mag;
                r_cnt <= CNT_W'(WIDTH);
                r_run <= 1'b1;
            end else if (r_run) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/calc_ctrl_n.sv
// Calculator controller: signed decimal operand entry, add/sub/mul, overflow.
// Define CALC_CHAIN_EN to let an operator in DONE chain on from the result.
module calc_ctrl_n
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    input  logic             clear_input,
    output logic             busy,
    output logic             complete,
    output logic             overflow,
    output logic [WIDTH-1:0] display_output,
    output state_t           tb_current_state
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int EW    = WIDTH + 4;
    localparam int PW    = 2 * WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_mag1, r_mag2;
    logic             r_sign1, r_sign2;
    logic [CNT_W-1:0] r_cnt1, r_cnt2;
    logic [2:0]       r_op;
    logic             r_busy, r_complete, r_overflow;
    logic [WIDTH-1:0] r_display;

    logic             r_read_q, r_digit_pls;
    logic [3:0]       r_digit_val;
    logic [2:0]       r_op_q, r_op_val;
    logic             r_op_pls;
    logic             r_eq_q, r_eq_pls;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        return neg ? -mag : mag;
    endfunction

    // Edge detectors register a one-cycle pulse that the FSM consumes on the
    // following clock; this stage sets the documented add/mul latencies.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_read_q    <= 1'b0;
            r_digit_pls <= 1'b0;
            r_digit_val <= '0;
            r_op_q      <= '0;
            r_op_pls    <= 1'b0;
            r_op_val    <= '0;
            r_eq_q      <= 1'b0;
            r_eq_pls    <= 1'b0;
        end else begin
            r_read_q    <= read_input;
            r_digit_pls <= read_input && !r_read_q && (keypad_input <= DIGIT_MAX);
            r_digit_val <= keypad_input;
            r_op_q      <= operator_input;
            r_op_pls    <= (r_op_q == 3'b000) && is_one_hot_op(operator_input);
            r_op_val    <= operator_input;
            r_eq_q      <= equal_input;
            r_eq_pls    <= equal_input && !r_eq_q;
        end
    end

    logic             w_in_op2;
    logic [WIDTH-1:0] w_cur_mag;
    logic             w_cur_sign;
    logic [CNT_W-1:0] w_cur_cnt;
    logic [EW-1:0]    w_cand, w_limit;
    logic             w_digit_ok, w_digit_room;
    logic [WIDTH-1:0] w_new_mag;

    assign w_in_op2     = (r_state == OP2_ENTRY);
    assign w_cur_mag    = w_in_op2 ? r_mag2  : r_mag1;
    assign w_cur_sign   = w_in_op2 ? r_sign2 : r_sign1;
    assign w_cur_cnt    = w_in_op2 ? r_cnt2  : r_cnt1;
    assign w_cand       = EW'(w_cur_mag) * EW'(10) + EW'(r_digit_val);
    // Negative operands may reach one step further: magnitude 2^(WIDTH-1).
    assign w_limit      = (EW'(1) << (WIDTH - 1)) - EW'(!w_cur_sign);
    assign w_digit_ok   = (w_cand <= w_limit);
    assign w_digit_room = (w_cur_cnt < CNT_W'(MAX_DIGITS));
    assign w_new_mag    = w_cand[WIDTH-1:0];

    logic [WIDTH-1:0] w_op1_s, w_op2_s;
    logic [WIDTH:0]   w_a, w_b, w_sum;
    logic             w_add_ovf;

    assign w_op1_s   = apply_sign(r_mag1, r_sign1);
    assign w_op2_s   = apply_sign(r_mag2, r_sign2);
    assign w_a       = {w_op1_s[WIDTH-1], w_op1_s};
    assign w_b       = {w_op2_s[WIDTH-1], w_op2_s};
    assign w_sum     = (r_op == OP_SUB) ? (w_a - w_b) : (w_a + w_b);
    assign w_add_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    logic             w_eq_go, w_mul_start, w_mul_done;
    logic [PW-1:0]    w_prod, w_mul_limit;
    logic             w_prod_neg, w_prod_zero, w_mul_ovf;
    logic [WIDTH-1:0] w_mul_res;

    assign w_eq_go     = !clear_input && r_eq_pls && w_in_op2;
    assign w_mul_start = w_eq_go && (r_op == OP_MUL);

    seq_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .nRST    (nRST),
        .start   (w_mul_start),
        .a_mag   (r_mag1),
        .b_mag   (r_mag2),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // A zero product is forced to +0 regardless of the operand signs.
    assign w_prod_neg  = r_sign1 ^ r_sign2;
    assign w_prod_zero = (w_prod == '0);
    assign w_mul_limit = (PW'(1) << (WIDTH - 1)) - PW'(!w_prod_neg);
    assign w_mul_ovf   = !w_prod_zero && (w_prod > w_mul_limit);
    assign w_mul_res   = w_prod_zero ? '0 : apply_sign(w_prod[WIDTH-1:0], w_prod_neg);

`ifdef CALC_CHAIN_EN
    logic             w_res_neg;
    logic [WIDTH-1:0] w_res_mag;

    assign w_res_neg = r_display[WIDTH-1];
    assign w_res_mag = w_res_neg ? -r_display : r_display;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= OP1_ENTRY;
            r_mag1     <= '0;
            r_mag2     <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_op       <= OP_ADD;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_overflow <= 1'b0;
            r_display  <= '0;
        end else if (clear_input) begin
            r_state    <= OP1_ENTRY;
            r_mag1     <= '0;
            r_mag2     <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_op       <= OP_ADD;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_overflow <= 1'b0;
            r_display  <= '0;
        end else begin
            case (r_state)
                OP1_ENTRY, OP2_ENTRY: begin
                    if (r_eq_pls) begin
                        if (w_eq_go) begin
                            r_state <= w_mul_start ? MUL_RUN : EXEC;
                            r_busy  <= 1'b1;
                        end
                    end else if (r_op_pls) begin
                        if (w_cur_cnt == '0) begin
                            if (r_op_val == OP_ADD) begin
                                if (w_in_op2) r_sign2 <= !r_sign2;
                                else          r_sign1 <= !r_sign1;
                            end
                        end else if (!w_in_op2) begin
                            r_op      <= r_op_val;
                            r_state   <= OP2_ENTRY;
                            r_display <= '0;
                        end
                    end else if (r_digit_pls && w_digit_room) begin
                        if (w_digit_ok) begin
                            if (w_in_op2) begin
                                r_mag2 <= w_new_mag;
                                r_cnt2 <= r_cnt2 + CNT_W'(1);
                            end else begin
                                r_mag1 <= w_new_mag;
                                r_cnt1 <= r_cnt1 + CNT_W'(1);
                            end
                            r_display <= apply_sign(w_new_mag, w_cur_sign);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end

                EXEC: begin
                    r_state    <= DONE;
                    r_busy     <= 1'b0;
                    r_complete <= 1'b1;
                    r_display  <= w_sum[WIDTH-1:0];
                    r_overflow <= w_add_ovf;
                end

                MUL_RUN: begin
                    if (w_mul_done) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_complete <= 1'b1;
                        r_display  <= w_mul_res;
                        r_overflow <= w_mul_ovf;
                    end
                end

                DONE: begin
                    if (r_op_pls) begin
`ifdef CALC_CHAIN_EN
                        r_state    <= OP2_ENTRY;
                        r_mag1     <= w_res_mag;
                        r_sign1    <= w_res_neg;
                        r_cnt1     <= CNT_W'(1);
                        r_mag2     <= '0;
                        r_sign2    <= 1'b0;
                        r_cnt2     <= '0;
                        r_op       <= r_op_val;
                        r_complete <= 1'b0;
                        r_overflow <= 1'b0;
                        r_display  <= '0;
`else
                        if (r_op_val == OP_ADD) begin
                            r_state    <= OP1_ENTRY;
                            r_mag1     <= '0;
                            r_sign1    <= 1'b1;
                            r_cnt1     <= '0;
                            r_mag2     <= '0;
                            r_sign2    <= 1'b0;
                            r_cnt2     <= '0;
                            r_op       <= OP_ADD;
                            r_complete <= 1'b0;
                            r_overflow <= 1'b0;
                            r_display  <= '0;
                        end
`endif
                    end else if (r_digit_pls) begin
                        r_state    <= OP1_ENTRY;
                        r_mag1     <= WIDTH'(r_digit_val);
                        r_sign1    <= 1'b0;
                        r_cnt1     <= CNT_W'(1);
                        r_mag2     <= '0;
                        r_sign2    <= 1'b0;
                        r_cnt2     <= '0;
                        r_op       <= OP_ADD;
                        r_complete <= 1'b0;
                        r_overflow <= 1'b0;
                        r_display  <= WIDTH'(r_digit_val);
                    end
                end

                default: r_state <= OP1_ENTRY;
            endcase
        end
    end

    assign busy             = r_busy;
    assign complete         = r_complete;
    assign overflow         = r_overflow;
    assign display_output   = r_display;
    assign tb_current_state = r_state;

endmodule

// File: tb/tb_calc_ctrl_n.sv
// Directed bench for calc_ctrl_n: a 16-bit and an 8-bit instance share stimulus.
// Chain-mode expectations switch on CALC_CHAIN_EN.
module tb_calc_ctrl_n;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  keypad_input = '0;
    logic        read_input = 1'b0;
    logic [2:0]  operator_input = '0;
    logic        equal_input = 1'b0;
    logic        clear_input = 1'b0;

    logic        busy16, complete16, ovf16;
    logic [15:0] disp16;
    state_t      st16;
    logic        busy8, complete8, ovf8;
    logic [7:0]  disp8;
    state_t      st8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    calc_ctrl_n #(.WIDTH(16), .MAX_DIGITS(5)) u_dut16 (
        .clk              (clk),
        .nRST             (nRST),
        .keypad_input     (keypad_input),
        .read_input       (read_input),
        .operator_input   (operator_input),
        .equal_input      (equal_input),
        .clear_input      (clear_input),
        .busy             (busy16),
        .complete         (complete16),
        .overflow         (ovf16),
        .display_output   (disp16),
        .tb_current_state (st16)
    );

    calc_ctrl_n #(.WIDTH(8), .MAX_DIGITS(5)) u_dut8 (
        .clk              (clk),
        .nRST             (nRST),
        .keypad_input     (keypad_input),
        .read_input       (read_input),
        .operator_input   (operator_input),
        .equal_input      (equal_input),
        .clear_input      (clear_input),
        .busy             (busy8),
        .complete         (complete8),
        .overflow         (ovf8),
        .display_output   (disp8),
        .tb_current_state (st8)
    );

    task automatic press_digit(input logic [3:0] d);
        keypad_input = d;
        read_input   = 1'b1;
        @(negedge clk);
        read_input   = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_op(input logic [2:0] code);
        operator_input = code;
        @(negedge clk);
        operator_input = 3'b000;
        @(negedge clk);
    endtask

    task automatic press_clear();
        clear_input = 1'b1;
        @(negedge clk);
        clear_input = 1'b0;
        @(negedge clk);
    endtask

    // lat = clocks after the edge-sampling posedge until complete16 is seen.
    task automatic press_eq(output int lat, output bit busy_bad);
        lat      = -1;
        busy_bad = 1'b0;
        equal_input = 1'b1;
        for (int i = 1; i <= 64 && lat < 0; i++) begin
            @(negedge clk);
            equal_input = 1'b0;
            if (complete16) lat = i - 1;
            else if (i >= 2 && !busy16) busy_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        n_tests++;
        if (st16 !== OP1_ENTRY) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", st16, OP1_ENTRY); end
        n_tests++;
        if ({busy16, complete16, ovf16} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy16, complete16, ovf16}); end
        n_tests++;
        if (disp16 !== 16'h0000 || disp8 !== 8'h00) begin n_fail++; $display("FAIL reset_display: got %h/%h expected 0000/00", disp16, disp8); end
    endtask

    task automatic test_add();
        int lat; bit bb;
        press_clear();
        press_digit(4'd2);
        press_op(OP_ADD);
        press_digit(4'd3);
        n_tests++;
        if (disp16 !== 16'h0003) begin n_fail++; $display("FAIL add_entry_display: got %h expected 0003", disp16); end
        press_eq(lat, bb);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
        n_tests++;
        if (bb) begin n_fail++; $display("FAIL add_busy: busy low before complete, expected high"); end
        n_tests++;
        if (disp16 !== 16'h0005 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h ovf %b expected 0005 ovf 0", disp16, ovf16); end
        n_tests++;
        if (st16 !== DONE || busy16 !== 1'b0) begin n_fail++; $display("FAIL add_done_state: got %0d busy %b expected %0d busy 0", st16, busy16, DONE); end
    endtask

    task automatic test_neg_add();
        int lat; bit bb;
        press_clear();
        press_op(OP_ADD);
        press_digit(4'd2);
        press_digit(4'd5);
        n_tests++;
        if (disp16 !== 16'hFFE7) begin n_fail++; $display("FAIL neg_entry_display: got %h expected ffe7", disp16); end
        press_op(OP_ADD);
        n_tests++;
        if (st16 !== OP2_ENTRY || disp16 !== 16'h0000) begin n_fail++; $display("FAIL op2_enter: got %0d/%h expected %0d/0000", st16, disp16, OP2_ENTRY); end
        press_op(OP_ADD);
        press_digit(4'd1);
        press_digit(4'd5);
        press_eq(lat, bb);
        n_tests++;
        if (disp16 !== 16'hFFD8 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL neg_add_result: got %h ovf %b expected ffd8 ovf 0", disp16, ovf16); end
    endtask

    task automatic test_mul();
        int lat; bit bb;
        press_clear();
        press_op(OP_ADD);
        press_digit(4'd3);
        press_op(OP_MUL);
        press_op(OP_ADD);
        press_digit(4'd6);
        press_eq(lat, bb);
        n_tests++;
        if (lat !== 18) begin n_fail++; $display("FAIL mul_latency: got %0d expected 18", lat); end
        n_tests++;
        if (bb) begin n_fail++; $display("FAIL mul_busy: busy low before complete, expected high"); end
        n_tests++;
        if (disp16 !== 16'd18 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL mul_neg_neg: got %h ovf %b expected 0012 ovf 0", disp16, ovf16); end
        press_clear();
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd8);
        press_op(OP_MUL);
        press_digit(4'd2); press_digit(4'd5); press_digit(4'd6);
        press_eq(lat, bb);
        n_tests++;
        if (disp16 !== 16'h8000 || ovf16 !== 1'b1) begin n_fail++; $display("FAIL mul_overflow: got %h ovf %b expected 8000 ovf 1", disp16, ovf16); end
        press_clear();
        press_op(OP_ADD);
        press_digit(4'd7);
        press_op(OP_MUL);
        press_digit(4'd0);
        press_eq(lat, bb);
        n_tests++;
        if (disp16 !== 16'h0000 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL mul_zero: got %h ovf %b expected 0000 ovf 0", disp16, ovf16); end
    endtask

    task automatic test_digit_range();
        press_clear();
        press_digit(4'd3); press_digit(4'd2); press_digit(4'd7);
        press_digit(4'd6); press_digit(4'd8);
        n_tests++;
        if (disp16 !== 16'h0CCC || ovf16 !== 1'b1) begin n_fail++; $display("FAIL range_pos_reject: got %h ovf %b expected 0ccc ovf 1", disp16, ovf16); end
        press_clear();
        press_op(OP_ADD);
        press_digit(4'd3); press_digit(4'd2); press_digit(4'd7);
        press_digit(4'd6); press_digit(4'd8);
        n_tests++;
        if (disp16 !== 16'h8000 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL range_neg_accept: got %h ovf %b expected 8000 ovf 0", disp16, ovf16); end
        press_digit(4'd1);
        n_tests++;
        if (disp16 !== 16'h8000 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL range_max_digits: got %h ovf %b expected 8000 ovf 0", disp16, ovf16); end
        press_digit(4'd12);
        n_tests++;
        if (disp16 !== 16'h8000) begin n_fail++; $display("FAIL illegal_key: got %h expected 8000", disp16); end
    endtask

    task automatic test_clear_mid_mul();
        bit seen;
        bit done_seen;
        press_clear();
        press_digit(4'd1); press_digit(4'd2);
        press_op(OP_MUL);
        press_digit(4'd3);
        seen = 1'b0;
        equal_input = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            equal_input = 1'b0;
            if (st16 == MUL_RUN) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL clr_mul_enter: got state %0d expected %0d", st16, MUL_RUN); end
        repeat (4) @(negedge clk);
        clear_input = 1'b1;
        @(negedge clk);
        clear_input = 1'b0;
        n_tests++;
        if (busy16 !== 1'b0 || st16 !== OP1_ENTRY || disp16 !== 16'h0000) begin
            n_fail++; $display("FAIL clr_mul_abort: got busy %b state %0d disp %h expected 0/%0d/0000", busy16, st16, disp16, OP1_ENTRY);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (complete16 || complete8) done_seen = 1'b1;
        end
        n_tests++;
        if (done_seen) begin n_fail++; $display("FAIL clr_mul_no_complete: complete rose after clear, expected it to stay low"); end
    endtask

    task automatic test_width8();
        int lat; bit bb;
        press_clear();
        press_digit(4'd1); press_digit(4'd0); press_digit(4'd0);
        press_op(OP_ADD);
        press_digit(4'd1); press_digit(4'd0); press_digit(4'd0);
        press_eq(lat, bb);
        n_tests++;
        if (disp8 !== 8'hC8 || ovf8 !== 1'b1 || complete8 !== 1'b1) begin
            n_fail++; $display("FAIL w8_add_ovf: got %h ovf %b cmp %b expected c8 ovf 1 cmp 1", disp8, ovf8, complete8);
        end
        n_tests++;
        if (disp16 !== 16'd200 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL w16_add_200: got %h ovf %b expected 00c8 ovf 0", disp16, ovf16); end
    endtask

    task automatic test_done_behaviour();
        press_digit(4'd7);
        n_tests++;
        if (st16 !== OP1_ENTRY || disp16 !== 16'h0007 || complete16 !== 1'b0) begin
            n_fail++; $display("FAIL done_digit: got %0d/%h cmp %b expected %0d/0007 cmp 0", st16, disp16, complete16, OP1_ENTRY);
        end
        n_tests++;
        if (ovf8 !== 1'b0 || disp8 !== 8'h07) begin n_fail++; $display("FAIL done_digit_w8: got %h ovf %b expected 07 ovf 0", disp8, ovf8); end
        press_op(3'b011);
        n_tests++;
        if (st16 !== OP1_ENTRY) begin n_fail++; $display("FAIL illegal_op: got %0d expected %0d", st16, OP1_ENTRY); end
        equal_input = 1'b1;
        @(negedge clk);
        equal_input = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (st16 !== OP1_ENTRY || busy16 !== 1'b0) begin n_fail++; $display("FAIL eq_in_op1: got %0d busy %b expected %0d busy 0", st16, busy16, OP1_ENTRY); end
    endtask

    task automatic test_chain();
        int lat; bit bb;
        press_clear();
        press_digit(4'd5);
        press_op(OP_ADD);
        press_digit(4'd3);
        press_eq(lat, bb);
        n_tests++;
        if (disp16 !== 16'h0008) begin n_fail++; $display("FAIL chain_base: got %h expected 0008", disp16); end
`ifdef CALC_CHAIN_EN
        press_op(OP_MUL);
        n_tests++;
        if (st16 !== OP2_ENTRY || disp16 !== 16'h0000) begin n_fail++; $display("FAIL chain_load: got %0d/%h expected %0d/0000", st16, disp16, OP2_ENTRY); end
        press_digit(4'd2);
        press_eq(lat, bb);
        n_tests++;
        if (disp16 !== 16'h0010 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL chain_mul: got %h ovf %b expected 0010 ovf 0", disp16, ovf16); end
`else
        press_op(OP_SUB);
        n_tests++;
        if (st16 !== DONE || disp16 !== 16'h0008 || complete16 !== 1'b1) begin
            n_fail++; $display("FAIL done_sub_ignored: got %0d/%h cmp %b expected %0d/0008 cmp 1", st16, disp16, complete16, DONE);
        end
        press_op(OP_ADD);
        n_tests++;
        if (st16 !== OP1_ENTRY || disp16 !== 16'h0000) begin n_fail++; $display("FAIL done_negate: got %0d/%h expected %0d/0000", st16, disp16, OP1_ENTRY); end
        press_digit(4'd4);
        n_tests++;
        if (disp16 !== 16'hFFFC) begin n_fail++; $display("FAIL done_negate_digit: got %h expected fffc", disp16); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_neg_add();
        test_mul();
        test_digit_range();
        test_clear_mid_mul();
        test_width8();
        test_done_behaviour();
        test_chain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
